// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath requantisers (sat0/sat1): default widths,
// lane count, saturation limits and the {real, imag} complex packing helpers.
package fft_pkg;

  localparam int DEF_NBITS_IN   = 28;
  localparam int DEF_NBITS_OUT  = 15;
  localparam int DEF_FRAC_SHIFT = 10;
  localparam int LANES          = 4;

  localparam logic signed [DEF_NBITS_OUT-1:0] SAT_MAX = {1'b0, {(DEF_NBITS_OUT-1){1'b1}}};
  localparam logic signed [DEF_NBITS_OUT-1:0] SAT_MIN = {1'b1, {(DEF_NBITS_OUT-1){1'b0}}};

  function automatic logic [2*DEF_NBITS_IN-1:0] packIn(
    input logic signed [DEF_NBITS_IN-1:0] re,
    input logic signed [DEF_NBITS_IN-1:0] im
  );
    return {re, im};
  endfunction

  function automatic logic [2*DEF_NBITS_OUT-1:0] packOut(
    input logic signed [DEF_NBITS_OUT-1:0] re,
    input logic signed [DEF_NBITS_OUT-1:0] im
  );
    return {re, im};
  endfunction

  function automatic logic signed [DEF_NBITS_OUT-1:0] unpackRe(input logic [2*DEF_NBITS_OUT-1:0] c);
    return c[2*DEF_NBITS_OUT-1:DEF_NBITS_OUT];
  endfunction

  function automatic logic signed [DEF_NBITS_OUT-1:0] unpackIm(input logic [2*DEF_NBITS_OUT-1:0] c);
    return c[DEF_NBITS_OUT-1:0];
  endfunction

endpackage

// File: rtl/requant_cplx.sv
// One complex lane of the requantiser: round half toward +inf, arithmetic shift, clamp.
// satHit flags the data sitting in stage 1, i.e. the value stage 2 is about to capture.
module requant_cplx
  import fft_pkg::*;
#(
  parameter int NBITS_IN   = DEF_NBITS_IN,
  parameter int NBITS_OUT  = DEF_NBITS_OUT,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   loadP1,
  input  logic                   loadP2,
  input  logic [2*NBITS_IN-1:0]  cplxRaw,
  output logic [2*NBITS_OUT-1:0] cplxQ,
  output logic                   satHit
);

  localparam int RW = NBITS_IN + 1;
  localparam logic signed [RW-1:0] RND   = RW'(2**(FRAC_SHIFT-1));
  localparam logic signed [RW-1:0] Q_MAX = RW'(2**(NBITS_OUT-1) - 1);
  localparam logic signed [RW-1:0] Q_MIN = RW'(-(2**(NBITS_OUT-1)));
  localparam logic signed [NBITS_OUT-1:0] OUT_MAX = {1'b0, {(NBITS_OUT-1){1'b1}}};
  localparam logic signed [NBITS_OUT-1:0] OUT_MIN = {1'b1, {(NBITS_OUT-1){1'b0}}};

  // One guard bit keeps the rounding add from overflowing at the positive extreme.
  function automatic logic signed [RW-1:0] roundHalfUp(input logic signed [NBITS_IN-1:0] x);
    return RW'(x) + RND;
  endfunction

  function automatic logic signed [RW-1:0] shiftQ(input logic signed [RW-1:0] r);
    return r >>> FRAC_SHIFT;
  endfunction

  function automatic logic isSat(input logic signed [RW-1:0] q);
    return (q > Q_MAX) || (q < Q_MIN);
  endfunction

  function automatic logic signed [NBITS_OUT-1:0] clampQ(input logic signed [RW-1:0] q);
    if (q > Q_MAX)
      return OUT_MAX;
    else if (q < Q_MIN)
      return OUT_MIN;
    else
      return q[NBITS_OUT-1:0];
  endfunction

  logic signed [NBITS_IN-1:0]  reRaw, imRaw;
  logic signed [RW-1:0]        re_p1, im_p1;
  logic signed [RW-1:0]        reQ, imQ;
  logic signed [NBITS_OUT-1:0] re_p2, im_p2;

  assign reRaw = cplxRaw[2*NBITS_IN-1:NBITS_IN];
  assign imRaw = cplxRaw[NBITS_IN-1:0];

  // Stage 1: sign-extend and add the rounding constant
  always_ff @(posedge clk) begin
    if (rst) begin
      re_p1 <= '0;
      im_p1 <= '0;
    end else if (loadP1) begin
      re_p1 <= roundHalfUp(reRaw);
      im_p1 <= roundHalfUp(imRaw);
    end
  end

  assign reQ    = shiftQ(re_p1);
  assign imQ    = shiftQ(im_p1);
  assign satHit = isSat(reQ) || isSat(imQ);

  // Stage 2: shift out the fraction and clamp to the output range
  always_ff @(posedge clk) begin
    if (rst) begin
      re_p2 <= '0;
      im_p2 <= '0;
    end else if (loadP2) begin
      re_p2 <= clampQ(reQ);
      im_p2 <= clampQ(imQ);
    end
  end

  assign cplxQ = {re_p2, im_p2};

endmodule

// File: rtl/requant_sat1.sv
// Second requantiser of the 4-parallel FFT: four complex lanes from 28 to 15 bits,
// with a 2-cycle valid pipe, a per-frame output index and saturation statistics.
module requant_sat1
  import fft_pkg::*;
#(
  parameter int NBITS_IN   = DEF_NBITS_IN,
  parameter int NBITS_OUT  = DEF_NBITS_OUT,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int N          = 32,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [2*NBITS_IN-1:0]  in0_up,
  input  logic [2*NBITS_IN-1:0]  in0_down,
  input  logic [2*NBITS_IN-1:0]  in1_up,
  input  logic [2*NBITS_IN-1:0]  in1_down,
  input  logic                   clr_stats,
  output logic [2*NBITS_OUT-1:0] out0_up,
  output logic [2*NBITS_OUT-1:0] out0_down,
  output logic [2*NBITS_OUT-1:0] out1_up,
  output logic [2*NBITS_OUT-1:0] out1_down,
  output logic                   out_valid,
  output logic                   frame_start,
  output logic                   sat_flag,
  output logic [CNT_W-1:0]       sat_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [2*NBITS_IN-1:0]  laneRaw [LANES];
  logic [2*NBITS_OUT-1:0] laneQ   [LANES];
  logic [LANES-1:0]       laneSat;
  logic                   vld_p1, vld_p2;
  logic                   satEvent;
  logic                   satFlag;
  logic [CNT_W-1:0]       satCount;
  logic [IDX_W-1:0]       frameIdx;

  assign laneRaw[0] = in0_up;
  assign laneRaw[1] = in0_down;
  assign laneRaw[2] = in1_up;
  assign laneRaw[3] = in1_down;

  for (genvar g = 0; g < LANES; g++) begin : gLane
    requant_cplx #(
      .NBITS_IN  (NBITS_IN),
      .NBITS_OUT (NBITS_OUT),
      .FRAC_SHIFT(FRAC_SHIFT)
    ) uLane (
      .clk    (clk),
      .rst    (rst),
      .loadP1 (in_valid),
      .loadP2 (vld_p1),
      .cplxRaw(laneRaw[g]),
      .cplxQ  (laneQ[g]),
      .satHit (laneSat[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
    end
  end

  // Stats are judged on stage-1 data so they become visible together with the output.
  assign satEvent = vld_p1 && (|laneSat);

  always_ff @(posedge clk) begin
    if (rst) begin
      satFlag  <= 1'b0;
      satCount <= '0;
    end else if (clr_stats) begin
      satFlag  <= satEvent;
      satCount <= satEvent ? CNT_W'(1) : '0;
    end else if (satEvent) begin
      satFlag <= 1'b1;
      if (satCount != '1)
        satCount <= satCount + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      frameIdx <= '0;
    else if (vld_p2)
      frameIdx <= (frameIdx == IDX_W'(N-1)) ? '0 : frameIdx + IDX_W'(1);
  end

  assign out0_up     = laneQ[0];
  assign out0_down   = laneQ[1];
  assign out1_up     = laneQ[2];
  assign out1_down   = laneQ[3];
  assign out_valid   = vld_p2;
  assign frame_start = vld_p2 && (frameIdx == '0);
  assign sat_flag    = satFlag;
  assign sat_count   = satCount;

endmodule

// File: tb/tb_requant_sat1.sv
// Directed and random checks of requant_sat1: rounding, clamping, latency, frame index,
// statistics, mid-stream reset and a bit-exact comparison against a floor-division model.
module tb_requant_sat1;
  import fft_pkg::*;

  localparam int NI = DEF_NBITS_IN;
  localparam int NO = DEF_NBITS_OUT;

  logic            clk = 1'b0;
  logic            rst, in_valid, clr_stats;
  logic [2*NI-1:0] in0_up, in0_down, in1_up, in1_down;
  logic [2*NO-1:0] out0_up, out0_down, out1_up, out1_down;
  logic            out_valid, frame_start, sat_flag;
  logic [15:0]     sat_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  requant_sat1 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in0_up     (in0_up),
    .in0_down   (in0_down),
    .in1_up     (in1_up),
    .in1_down   (in1_down),
    .clr_stats  (clr_stats),
    .out0_up    (out0_up),
    .out0_down  (out0_down),
    .out1_up    (out1_up),
    .out1_down  (out1_down),
    .out_valid  (out_valid),
    .frame_start(frame_start),
    .sat_flag   (sat_flag),
    .sat_count  (sat_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkCnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkCplx(input string tag, input logic [2*NO-1:0] obs, input logic [2*NO-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkWide(input string tag, input logic [8*NO-1:0] obs, input logic [8*NO-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*NI-1:0] mkIn(input int re, input int im);
    return packIn(NI'(re), NI'(im));
  endfunction

  function automatic logic [2*NO-1:0] mkOut(input int re, input int im);
    return packOut(NO'(re), NO'(im));
  endfunction

  task automatic setLanes(input logic [2*NI-1:0] a, input logic [2*NI-1:0] b,
                          input logic [2*NI-1:0] c, input logic [2*NI-1:0] d);
    in0_up   = a;
    in0_down = b;
    in1_up   = c;
    in1_down = d;
  endtask

  // Reference: floor((x + 512) / 1024) via integer division, then clamp to 15-bit range.
  function automatic int refComp(input int x, output bit sat);
    longint t, q;
    t = longint'(x) + 64'sd512;
    if (t >= 0) q = t / 1024;
    else        q = -((-t + 1023) / 1024);
    sat = 1'b0;
    if (q > 16383)       begin q = 16383;  sat = 1'b1; end
    else if (q < -16384) begin q = -16384; sat = 1'b1; end
    return int'(q);
  endfunction

  function automatic int rnd28();
    logic [31:0] r;
    r = $urandom;
    case (r[31:30])
      2'd0:    return int'($signed(r[27:0]));
      2'd3:    return int'($signed(r[15:0]));
      default: return int'($signed(r[25:0]));
    endcase
  endfunction

  // Runs a fresh frame from reset; fsA/fsB/fsC are the input cycles whose outputs carry frame_start.
  task automatic frameRun(input int nIn, input int gapAt, input int gapLen,
                          input int fsA, input int fsB, input int fsC);
    int  p;
    logic expV;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c <= nIn + 1; c++) begin
      in_valid = (c < nIn) && !(c >= gapAt && c < gapAt + gapLen);
      tick();
      if (c >= 1) begin
        p = c - 1;
        expV = (p < nIn) && !(p >= gapAt && p < gapAt + gapLen);
        chkBit("frame_valid", out_valid, expV);
        chkBit("frame_start", frame_start, (p == fsA) || (p == fsB) || (p == fsC));
      end
    end
    in_valid = 1'b0;
  endtask

  int rv[4] = '{1535, 1536, -1536, -1537};
  int rq[4] = '{1, 2, -1, -2};
  int rn[4] = '{-1, -1, 2, 2};

  initial begin
    int re[4];
    int im[4];
    int qr, qi;
    bit sr, si, anySat, v, expPrevV;
    int evCount;
    logic [8*NO-1:0] expCur, expPrev;

    rst = 1'b1;
    in_valid = 1'b0;
    clr_stats = 1'b0;
    setLanes('0, '0, '0, '0);
    repeat (3) tick();
    chkBit("reset_valid", out_valid, 1'b0);
    chkBit("reset_fs", frame_start, 1'b0);
    chkBit("reset_flag", sat_flag, 1'b0);
    chkCnt("reset_count", sat_count, 16'd0);
    chkCplx("reset_out0u", out0_up, '0);
    chkCplx("reset_out1d", out1_down, '0);
    rst = 1'b0;
    tick();

    // Rounding across the half-LSB boundaries, two-cycle latency, hold when idle
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) setLanes(mkIn(rv[i], 0), mkIn(0, rv[i]), mkIn(rv[i], rv[i]), mkIn(-rv[i], 0));
      else       in_valid = 1'b0;
      tick();
      if (i == 0) chkBit("latency_not_1", out_valid, 1'b0);
      if (i >= 1 && i <= 4) begin
        chkBit("rnd_valid", out_valid, 1'b1);
        chkCplx("rnd_l0up", out0_up, mkOut(rq[i-1], 0));
        chkCplx("rnd_l0dn", out0_down, mkOut(0, rq[i-1]));
        chkCplx("rnd_l1up", out1_up, mkOut(rq[i-1], rq[i-1]));
        chkCplx("rnd_l1dn", out1_down, mkOut(rn[i-1], 0));
      end
      if (i == 5) begin
        chkBit("hold_valid", out_valid, 1'b0);
        chkCplx("hold_data", out0_up, mkOut(-2, 0));
      end
    end
    chkCnt("rnd_nosat_count", sat_count, 16'd0);
    chkBit("rnd_nosat_flag", sat_flag, 1'b0);

    // Saturation on lane 0 only; other lanes stay exact
    in_valid = 1'b1;
    setLanes(mkIn(1 << 24, -(1 << 25)), mkIn(1536, -1537), mkIn(0, 0), mkIn(-1537, 1535));
    tick();
    in_valid = 1'b0;
    tick();
    chkBit("sat_valid", out_valid, 1'b1);
    chkCplx("sat_l0up", out0_up, mkOut(16383, -16384));
    chkCplx("sat_l0dn", out0_down, mkOut(2, -2));
    chkCplx("sat_l1dn", out1_down, mkOut(-2, 1));
    chkBit("sat_flag", sat_flag, 1'b1);
    chkCnt("sat_count", sat_count, 16'd1);

    // Largest values that land exactly on the limits without saturating
    in_valid = 1'b1;
    setLanes(mkIn(0, 0), mkIn(0, 0), mkIn(16776703, -16777728), mkIn(0, 0));
    tick();
    in_valid = 1'b0;
    tick();
    chkCplx("edge_l1up", out1_up, mkOut(16383, -16384));
    chkCnt("edge_nosat_count", sat_count, 16'd1);

    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chkBit("clr_flag", sat_flag, 1'b0);
    chkCnt("clr_count", sat_count, 16'd0);

    // Two events, then a clear coinciding with a third event
    in_valid = 1'b1;
    setLanes(mkIn(1 << 24, -(1 << 25)), mkIn(0, 0), mkIn(0, 0), mkIn(0, 0));
    repeat (3) tick();
    chkCnt("pre_clr_count", sat_count, 16'd2);
    in_valid = 1'b0;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chkCnt("clr_event_count", sat_count, 16'd1);
    chkBit("clr_event_flag", sat_flag, 1'b1);
    tick();

    // Reset during a valid burst
    in_valid = 1'b1;
    setLanes(mkIn(1536, 0), mkIn(1536, 0), mkIn(1536, 0), mkIn(1536, 0));
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkBit("rst_mid_valid", out_valid, 1'b0);
    chkCplx("rst_mid_out0u", out0_up, '0);
    chkCplx("rst_mid_out1d", out1_down, '0);
    chkCnt("rst_mid_count", sat_count, 16'd0);
    setLanes(mkIn(3584, 0), mkIn(3584, 0), mkIn(3584, 0), mkIn(3584, 0));
    tick();
    chkBit("rst_no_stale", out_valid, 1'b0);
    tick();
    chkBit("rst_first_valid", out_valid, 1'b1);
    chkBit("rst_first_fs", frame_start, 1'b1);
    chkCplx("rst_first_data", out0_up, mkOut(4, 0));
    in_valid = 1'b0;
    repeat (2) tick();

    frameRun(70, 0, 0, 0, 32, 64);
    frameRun(48, 10, 3, 0, 35, -1);

    // Counter must stop at all-ones rather than wrap
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    in_valid = 1'b1;
    setLanes(mkIn(1 << 24, 0), mkIn(0, 0), mkIn(0, 0), mkIn(0, 0));
    repeat (65541) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chkCnt("count_holds", sat_count, 16'hFFFF);
    chkBit("count_holds_flag", sat_flag, 1'b1);

    // Random products against the reference model
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    evCount = 0;
    expPrevV = 1'b0;
    expPrev = '0;
    for (int c = 0; c <= 10000; c++) begin
      v = (c < 10000) && ($urandom_range(9, 0) != 0);
      anySat = 1'b0;
      for (int l = 0; l < 4; l++) begin
        re[l] = rnd28();
        im[l] = rnd28();
        qr = refComp(re[l], sr);
        qi = refComp(im[l], si);
        anySat = anySat | sr | si;
        expCur[(3-l)*2*NO +: 2*NO] = mkOut(qr, qi);
      end
      if (v && anySat) evCount++;
      in_valid = v;
      setLanes(mkIn(re[0], im[0]), mkIn(re[1], im[1]), mkIn(re[2], im[2]), mkIn(re[3], im[3]));
      tick();
      chkBit("rand_valid", out_valid, expPrevV);
      if (expPrevV)
        chkWide("rand_data", {out0_up, out0_down, out1_up, out1_down}, expPrev);
      expPrev = expCur;
      expPrevV = v;
    end
    in_valid = 1'b0;
    chkCnt("rand_sat_count", sat_count, 16'(evCount));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
